pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Takes the ID-stage load-use stall and jump/branch requests, the MEM-stage memory handshake (MIO_ready) and a debug halt/step interface. Drives the per-stage register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Sits at CPU top level beside the stage modules and replaces their ad-hoc stall wiring.

Parameters:
MEM_TIMEOUT, 15, MEM_WAIT cycles before a memory-timeout error is declared (1..255)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at posedge resets)
id_shouldStall  input  1  load-use hazard detected in ID
id_shouldJumpOrBranch  input  1  ID resolved a taken jump/branch
mem_access  input  1  MEM stage holds a load or store
MIO_ready  input  1  memory completes access this cycle
dbg_halt  input  1  level; request to halt the pipeline
dbg_step  input  1  one-cycle pulse; advance one cycle while halted
pc_en  output  1  PC register load enable
pc_sel_redirect  output  1  PC takes jumpOrBranchPc
ifid_en  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads a NOP
idex_en  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads a bubble
exmem_en  output  1  EX/MEM load enable
memwb_flush  output  1  MEM/WB loads a bubble
halted  output  1  state is HALT or ERR
mem_timeout  output  1  sticky error flag
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  redirect cycles, saturating

Behaviour:
- States: RUN, MEM_WAIT, HALT, STEP, ERR. Reset -> RUN; wait_cnt=0, counters=0, mem_timeout=0.
- Outputs are combinational from state and inputs. Define FREEZE: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, all other flushes/redirect 0.
- "Normal" decode (used in RUN and STEP), evaluated in priority order:
  1. mem_access & !MIO_ready: FREEZE.
  2. else id_shouldStall: pc_en=0, ifid_en=0, idex_flush=1; idex_en=exmem_en=1; redirect ignored this cycle.
  3. else id_shouldJumpOrBranch: pc_en=1, pc_sel_redirect=1, ifid_flush=1; other enables 1.
  4. else: all enables 1, no flushes.
- Defaults when not listed: enables 1, flushes 0, pc_sel_redirect 0.
- RUN: case 1 -> MEM_WAIT with wait_cnt=1. Else if dbg_halt -> HALT; the current cycle still advances per the normal decode. Otherwise stay in RUN.
- MEM_WAIT: FREEZE.
  - If MIO_ready: -> RUN, wait_cnt=0.
  - Else if wait_cnt==MEM_TIMEOUT: -> ERR.
  - Else wait_cnt+1.
  - dbg_halt is ignored in MEM_WAIT; it is taken once back in RUN.
- HALT: FREEZE, halted=1.
  - dbg_step=1 -> STEP.
  - dbg_halt=0 (and no step) -> RUN.
  - If step and release coincide, step wins.
- STEP: exactly one cycle with the normal decode, halted=0.
  - If case 1 applies -> MEM_WAIT.
  - Else if dbg_halt -> HALT, else -> RUN.
- ERR: FREEZE, halted=1, mem_timeout=1. Leaves only via reset; all inputs ignored.
- Counters:
  - stall_count +1 in each cycle where case 2 drives the outputs.
  - flush_count +1 in each cycle where case 3 drives the outputs.
  - Both saturate at all-ones and do not count in FREEZE cycles.
- Reset asserted in any state (including MEM_WAIT and ERR) returns to RUN on that edge and clears everything.

Test Plan:
- Reset then idle inputs: pc_en=ifid_en=idex_en=exmem_en=1, all flushes 0, halted=0, counters 0.
- id_shouldStall=1 for 2 cycles with id_shouldJumpOrBranch=1 in the same cycles -> pc_en=0, ifid_en=0, idex_flush=1, no redirect; stall_count=2, flush_count=0.
- mem_access=1, MIO_ready low for 4 cycles then high -> FREEZE for 5 cycles, normal decode on the 6th; counters unchanged.
- MEM_TIMEOUT=3, MIO_ready stuck low -> ERR after 4 frozen cycles with mem_timeout=1. Later MIO_ready=1 has no effect; rst=0 for one edge clears mem_timeout and returns to RUN.
- dbg_halt=1 -> HALT next cycle. A dbg_step pulse with id_shouldJumpOrBranch=1 -> one cycle with pc_sel_redirect=1 and ifid_flush=1, then HALT again; flush_count=1.
- HALT with dbg_halt dropping in the same cycle as dbg_step=1 -> STEP, then RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, redirects,
// memory wait with timeout, and a debug halt/single-step interface.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_shouldStall,
  input  logic             id_shouldJumpOrBranch,
  input  logic             mem_access,
  input  logic             MIO_ready,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    RUN,
    MEM_WAIT,
    HALT,
    STEP,
    ERR
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

  logic normalDecode;
  logic memBlock;
  logic doStall;
  logic doJump;
  logic freeze;

  // Normal decode applies only in RUN and STEP; every other state freezes.
  always_comb begin
    normalDecode = (state_q == RUN) || (state_q == STEP);
    memBlock     = mem_access & ~MIO_ready;
    doStall      = normalDecode & ~memBlock & id_shouldStall;
    doJump       = normalDecode & ~memBlock & ~id_shouldStall & id_shouldJumpOrBranch;
    freeze       = ~normalDecode | memBlock;

    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_en         = 1'b1;
    ifid_flush      = 1'b0;
    idex_en         = 1'b1;
    idex_flush      = 1'b0;
    exmem_en        = 1'b1;
    memwb_flush     = 1'b0;

    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (doStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (doJump) begin
      pc_sel_redirect = 1'b1;
      ifid_flush      = 1'b1;
    end

    halted      = (state_q == HALT) || (state_q == ERR);
    mem_timeout = (state_q == ERR);
    stall_count = stallCnt_q;
    flush_count = flushCnt_q;
  end

  // Next-state logic; a memory block outranks a halt request.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;

    if (doStall && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
    if (doJump && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);

    unique case (state_q)
      RUN, STEP: begin
        if (memBlock) begin
          state_d   = MEM_WAIT;
          waitCnt_d = 8'd1;
        end else if (dbg_halt) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (MIO_ready) begin
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else if (waitCnt_q == 8'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      HALT: begin
        if (dbg_step)       state_d = STEP;
        else if (!dbg_halt) state_d = RUN;
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      waitCnt_q  <= 8'd0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {pc_en, redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted, mem_timeout}
  localparam logic [9:0] NORM  = 10'b1010101000;
  localparam logic [9:0] STALL = 10'b0000111000;
  localparam logic [9:0] JUMP  = 10'b1111101000;
  localparam logic [9:0] FRZ   = 10'b0000000100;
  localparam logic [9:0] HLT   = 10'b0000000110;
  localparam logic [9:0] ERRV  = 10'b0000000111;

  typedef struct {
    logic [9:0] outs;
    int         stalls;
    int         flushes;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_shouldStall, id_shouldJumpOrBranch, mem_access, MIO_ready, dbg_halt, dbg_step;
  logic pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_flush, halted, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_shouldStall(id_shouldStall), .id_shouldJumpOrBranch(id_shouldJumpOrBranch),
    .mem_access(mem_access), .MIO_ready(MIO_ready),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    act = {pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_flush, halted, mem_timeout};
    checks++;
    if (act !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %b expected %b", e.name, act, e.outs);
    end
    checks++;
    if (int'(stall_count) != e.stalls || int'(flush_count) != e.flushes) begin
      errors++;
      $display("[TB] FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               e.name, stall_count, flush_count, e.stalls, e.flushes);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic r, input logic st, input logic jb, input logic ma,
                               input logic rdy, input logic hl, input logic sp,
                               input logic [9:0] outs, input int s, input int f, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_shouldStall = st; id_shouldJumpOrBranch = jb;
    mem_access = ma; MIO_ready = rdy; dbg_halt = hl; dbg_step = sp;
    e.outs = outs; e.stalls = s; e.flushes = f; e.name = name;
    expQ.push_back(e);
  endtask

  initial begin
    rst = 1'b0; id_shouldStall = 1'b0; id_shouldJumpOrBranch = 1'b0;
    mem_access = 1'b0; MIO_ready = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;
    repeat (2) @(posedge clk);

    //             rst st jb ma rdy hl sp  outs   s  f
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  0, 0, "reset_idle");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, STALL, 0, 0, "stall_jb_1");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, STALL, 1, 0, "stall_jb_2");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  2, 0, "after_stall");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 1, 0, 0, 0, FRZ, 2, 0, "mem_wait_low");
    applyStimulus(1, 0, 0, 1, 1, 0, 0, FRZ,   2, 0, "mem_wait_ready");
    applyStimulus(1, 0, 1, 1, 1, 0, 0, JUMP,  2, 0, "post_mem_jump");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  2, 1, "after_jump");

    applyStimulus(1, 0, 0, 0, 0, 1, 0, NORM,  2, 1, "halt_request");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, HLT,   2, 1, "halted");
    applyStimulus(1, 0, 1, 0, 0, 1, 1, HLT,   2, 1, "step_pulse");
    applyStimulus(1, 0, 1, 0, 0, 1, 0, JUMP,  2, 1, "step_jump");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, HLT,   2, 2, "rehalted");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, HLT,   2, 2, "step_and_release");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, STALL, 2, 2, "step_stall");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  3, 2, "run_after_step");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, NORM,  3, 2, "halt_again");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, HLT,   3, 2, "release_halt");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  3, 2, "run_after_release");

    applyStimulus(1, 0, 0, 1, 0, 1, 0, FRZ,   3, 2, "mem_beats_halt");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, FRZ,   3, 2, "halt_ignored_wait");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, FRZ,   3, 2, "wait_done_halt");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, NORM,  3, 2, "halt_taken_in_run");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, HLT,   3, 2, "halt_then_release");

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 0, 1, 0, 0, 0, FRZ, 3, 2, "timeout_frozen");
    applyStimulus(1, 0, 0, 1, 1, 0, 0, ERRV,  3, 2, "err_ignores_ready");
    applyStimulus(1, 1, 1, 0, 0, 1, 1, ERRV,  3, 2, "err_ignores_inputs");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, ERRV,  3, 2, "err_during_reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  0, 0, "reset_clears_err");
    applyStimulus(1, 0, 1, 0, 0, 0, 0, JUMP,  0, 0, "jump_after_reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  0, 1, "idle_after_jump");

    for (int i = 0; i < 17; i++)
      applyStimulus(1, 1, 0, 0, 0, 0, 0, STALL, (i < 15) ? i : 15, 1, "stall_saturate");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, NORM,  15, 1, "saturated_hold");

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
